// File: rtl/i2cmb_burst_sequencer.sv
// Burst sequencer for an iicmb I2C master: expands one request into the
// SETBUS/START/ADDR/DATA/STOP command stream over a Wishbone master port.
module i2cmb_burst_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSES  = 1,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_op_i,
    input  logic [LEN_W-1:0]          req_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [7:0]                wdata_i,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    output logic                      done_o,
    output logic [2:0]                err_code_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

    typedef enum logic [3:0] {S_INIT, S_IDLE, S_WB, S_GAP, S_CMD, S_IRQ,
                              S_DEC, S_FETCH, S_RNEXT, S_DONE} state_t;
    typedef enum logic [2:0] {P_SETBUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

    state_t                    state_q, state_d, ret_q, ret_d;
    phase_t                    phase_q, phase_d;
    logic                      we_q, we_d, op_q, op_d, cvld_q, cvld_d, rdv_q, rdv_d;
    logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]  wdat_q, wdat_d;
    logic [3:0]                stat_q, stat_d, bus_q, bus_d, cbus_q, cbus_d;
    logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]          len_q, len_d, cnt_q, cnt_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [2:0]                res_q, res_d, err_q, err_d, cmd;
    logic [7:0]                rdata_q, rdata_d;
    logic                      last_byte;

    assign last_byte = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        case (phase_q)
            P_SETBUS: cmd = 3'b110;
            P_START:  cmd = 3'b100;
            P_ADDR:   cmd = 3'b001;
            P_DATA:   cmd = !op_q ? 3'b001 : (last_byte ? 3'b011 : 3'b010);
            default:  cmd = 3'b101;
        endcase
    end

    always_comb begin
        state_d = state_q;  ret_d  = ret_q;   phase_d = phase_q;
        we_d    = we_q;     adr_d  = adr_q;   wdat_d  = wdat_q;
        stat_d  = stat_q;   bus_d  = bus_q;   addr_d  = addr_q;
        op_d    = op_q;     len_d  = len_q;   cnt_d   = cnt_q;
        tmo_d   = tmo_q;    res_d  = res_q;   err_d   = err_q;
        cvld_d  = cvld_q;   cbus_d = cbus_q;  rdata_d = rdata_q;
        rdv_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                we_d = 1'b1; adr_d = A_CSR; wdat_d = WB_DATA_WIDTH'(8'hC0);
                ret_d = S_IDLE; state_d = S_WB;
            end
            S_IDLE: if (req_valid_i) begin
                bus_d = req_bus_i; addr_d = req_addr_i; op_d = req_op_i;
                len_d = req_len_i; res_d = 3'b000;
                if (32'(req_bus_i) >= NUM_I2C_BUSES || 32'(req_len_i) > MAX_BURST) begin
                    res_d = 3'b101; state_d = S_DONE;
                end else if (cvld_q && cbus_q == req_bus_i) begin
                    phase_d = P_START; state_d = S_CMD;
                end else begin
                    phase_d = P_SETBUS; we_d = 1'b1; adr_d = A_DPR;
                    wdat_d = WB_DATA_WIDTH'(req_bus_i); ret_d = S_CMD; state_d = S_WB;
                end
            end
            S_WB: if (ack_i) begin
                stat_d = dat_i[7:4];
                if (!we_q && adr_q == A_DPR) begin
                    rdata_d = dat_i[7:0]; rdv_d = 1'b1;
                end
                state_d = S_GAP;
            end
            // Mandatory idle cycle between Wishbone accesses.
            S_GAP: state_d = ret_q;
            S_CMD: begin
                we_d = 1'b1; adr_d = A_CMDR; wdat_d = WB_DATA_WIDTH'(cmd);
                tmo_d = '0; ret_d = S_IRQ; state_d = S_WB;
            end
            S_IRQ: begin
                if (irq_i) begin
                    we_d = 1'b0; adr_d = A_CMDR; ret_d = S_DEC; state_d = S_WB;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                    res_d = 3'b100; cvld_d = 1'b0; state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            // Status priority AL > ERR > NAK > DON; a status without DON is treated as ERR.
            S_DEC: begin
                if (stat_q[1]) begin
                    res_d = 3'b010; cvld_d = 1'b0; state_d = S_DONE;
                end else if (stat_q[0] || !stat_q[3]) begin
                    res_d = 3'b011; cvld_d = 1'b0; state_d = S_DONE;
                end else if (stat_q[2]) begin
                    res_d = 3'b001;
                    if (phase_q == P_STOP) state_d = S_DONE;
                    else begin phase_d = P_STOP; state_d = S_CMD; end
                end else begin
                    case (phase_q)
                        P_SETBUS: begin
                            cvld_d = 1'b1; cbus_d = bus_q; phase_d = P_START; state_d = S_CMD;
                        end
                        P_START: begin
                            phase_d = P_ADDR; we_d = 1'b1; adr_d = A_DPR;
                            wdat_d = WB_DATA_WIDTH'({addr_q, op_q}); ret_d = S_CMD; state_d = S_WB;
                        end
                        P_ADDR: begin
                            cnt_d = '0;
                            if (len_q == '0) begin phase_d = P_STOP; state_d = S_CMD; end
                            else begin phase_d = P_DATA; state_d = op_q ? S_CMD : S_FETCH; end
                        end
                        P_DATA: begin
                            if (op_q) begin
                                we_d = 1'b0; adr_d = A_DPR; ret_d = S_RNEXT; state_d = S_WB;
                            end else if (last_byte) begin
                                phase_d = P_STOP; state_d = S_CMD;
                            end else begin
                                cnt_d = cnt_q + LEN_W'(1); state_d = S_FETCH;
                            end
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_FETCH: if (wdata_valid_i) begin
                we_d = 1'b1; adr_d = A_DPR; wdat_d = WB_DATA_WIDTH'(wdata_i);
                ret_d = S_CMD; state_d = S_WB;
            end
            S_RNEXT: begin
                if (last_byte) phase_d = P_STOP;
                else cnt_d = cnt_q + LEN_W'(1);
                state_d = S_CMD;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) err_d = res_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT; ret_q  <= S_IDLE; phase_q <= P_SETBUS;
            we_q    <= 1'b0;   adr_q  <= '0;     wdat_q  <= '0;
            stat_q  <= '0;     bus_q  <= '0;     addr_q  <= '0;
            op_q    <= 1'b0;   len_q  <= '0;     cnt_q   <= '0;
            tmo_q   <= '0;     res_q  <= '0;     err_q   <= '0;
            cvld_q  <= 1'b0;   cbus_q <= '0;     rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d; ret_q  <= ret_d;  phase_q <= phase_d;
            we_q    <= we_d;    adr_q  <= adr_d;  wdat_q  <= wdat_d;
            stat_q  <= stat_d;  bus_q  <= bus_d;  addr_q  <= addr_d;
            op_q    <= op_d;    len_q  <= len_d;  cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;   res_q  <= res_d;  err_q   <= err_d;
            cvld_q  <= cvld_d;  cbus_q <= cbus_d; rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
        end
    end

    assign cyc_o         = (state_q == S_WB);
    assign stb_o         = (state_q == S_WB);
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = wdat_q;
    assign req_ready_o   = (state_q == S_IDLE);
    assign wdata_ready_o = (state_q == S_FETCH);
    assign done_o        = (state_q == S_DONE);
    assign err_code_o    = err_q;
    assign rdata_valid_o = rdv_q;
    assign rdata_o       = rdata_q;
endmodule

// File: tb/tb_i2cmb_burst_sequencer.sv
// Randomized directed bench: an iicmb-like Wishbone slave plus a transaction-level
// model that predicts the register write trace, read bytes and completion code.
module tb_i2cmb_burst_sequencer;
    localparam int NB = 2, MAXB = 64, TMO = 100, LEN_W = 7;

    logic clk = 1'b0, rst;
    logic req_valid, req_ready_o, req_op, wdata_valid, wdata_ready_o;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [LEN_W-1:0] req_len;
    logic [7:0] wdata, rdata_o, dat_o, dat_i;
    logic rdata_valid_o, done_o, cyc_o, stb_o, we_o, ack_i, irq_i;
    logic [2:0] err_code_o;
    logic [1:0] adr_o;

    always #5 clk = ~clk;

    i2cmb_burst_sequencer #(.NUM_I2C_BUSES(NB), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_op_i(req_op), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .err_code_o(err_code_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i));

    int n_assert = 0, n_fail = 0;
    logic [9:0] trace[$], exp_q[$];
    logic [7:0] exp_rd[$], slv_rd[$];
    logic [7:0] wbytes[MAXB], rbytes[MAXB];
    logic [2:0] exp_err;
    bit   mc_vld = 0;
    logic [3:0] mc_bus = 0;
    int mk, nak_at = -1, al_at = -1, hang_at = -1, cmd_idx = 0;
    int nacc = 0, viol = 0, dcyc = 0, nacc_base = 0;
    bit slow = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slave: random ack latency, irq a few cycles after each command write.
    initial begin
        bit pend = 0;
        int lat = 0, irq_cnt = -1;
        logic cap_we = 0;
        logic [1:0] cap_adr = 0;
        logic [7:0] cap_dat = 0, status = 8'h80;
        logic [10:0] snap = 0;
        ack_i = 0; dat_i = 0; irq_i = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_i = 0; irq_i = 0; irq_cnt = -1; pend = 0;
            end else if (ack_i) begin
                ack_i = 0; nacc++; pend = 0;
                if (cap_we) begin
                    trace.push_back({cap_adr, cap_dat});
                    if (cap_adr == 2'd2) begin
                        status = 8'h80;
                        if (cmd_idx == nak_at) status = 8'hC0;
                        if (cmd_idx == al_at) status = 8'hA0;
                        irq_cnt = (cmd_idx == hang_at) ? -1 : int'($urandom_range(0, 4));
                        cmd_idx++;
                    end
                end else if (cap_adr == 2'd2) irq_i = 0;
                if (stb_o) viol++;
            end else if (stb_o) begin
                if (!pend) begin
                    pend = 1; lat = slow ? 4 : int'($urandom_range(0, 2));
                    snap = {we_o, adr_o, dat_o};
                end else if (snap !== {we_o, adr_o, dat_o}) viol++;
                if (lat == 0) begin
                    ack_i = 1; cap_we = we_o; cap_adr = adr_o; cap_dat = dat_o;
                    if (!we_o && adr_o == 2'd2) dat_i = status;
                    else if (!we_o && adr_o == 2'd1) dat_i = (slv_rd.size() != 0) ? slv_rd.pop_front() : 8'h00;
                    else dat_i = 8'h00;
                end else lat--;
            end else pend = 0;
            if (irq_cnt == 0) begin irq_i = 1; irq_cnt = -1; end
            else if (irq_cnt > 0) irq_cnt--;
        end
    end

    function automatic int issue(input logic [7:0] c);
        exp_q.push_back({2'd2, c});
        mk++;
        if (mk - 1 == al_at)   begin exp_err = 3'b010; mc_vld = 0; return 2; end
        if (mk - 1 == hang_at) begin exp_err = 3'b100; mc_vld = 0; return 2; end
        if (mk - 1 == nak_at)  begin exp_err = 3'b001; return 1; end
        return 0;
    endfunction

    task automatic model(input logic [3:0] b, input logic [6:0] a, input logic op, input int len);
        int r;
        exp_q.delete(); exp_rd.delete(); mk = 0; exp_err = 3'b000;
        if (b >= NB || len > MAXB) begin exp_err = 3'b101; return; end
        if (!(mc_vld && mc_bus == b)) begin
            exp_q.push_back({2'd1, 4'd0, b});
            r = issue(8'd6);
            if (r == 2) return;
            mc_vld = 1; mc_bus = b;
        end
        r = issue(8'd4);
        if (r == 2) return;
        exp_q.push_back({2'd1, a, op});
        r = issue(8'd1);
        if (r == 2) return;
        for (int i = 0; i < len && r == 0; i++) begin
            if (!op) begin exp_q.push_back({2'd1, wbytes[i]}); r = issue(8'd1); end
            else begin
                r = issue((i == len - 1) ? 8'd3 : 8'd2);
                if (r == 0) exp_rd.push_back(rbytes[i]);
            end
        end
        if (r == 2) return;
        void'(issue(8'd5));
    endtask

    function automatic bit trace_eq();
        if (trace.size() != exp_q.size()) return 0;
        foreach (trace[i]) if (trace[i] !== exp_q[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string tag);
        int c = 0;
        @(negedge clk);
        while (!req_ready_o && c < 300) begin @(negedge clk); c++; end
        check(tag, req_ready_o, 1'b1);
    endtask

    task automatic run_txn(input logic [3:0] b, input logic [6:0] a, input logic op, input int len);
        logic [7:0] got_rd[$];
        bit got = 0, rd_ok;
        logic [2:0] gerr = 3'b111;
        int widx = 0;
        model(b, a, op, len);
        wait_idle("idle_before_req");
        cmd_idx = 0; trace.delete(); slv_rd.delete(); nacc_base = nacc;
        for (int i = 0; i < len && i < MAXB; i++) slv_rd.push_back(rbytes[i]);
        req_valid = 1; req_bus = b; req_addr = a; req_op = op; req_len = LEN_W'(len);
        @(posedge clk);
        for (int c = 1; c <= 6000 && !got; c++) begin
            @(negedge clk);
            req_valid = 0;
            if (rdata_valid_o) got_rd.push_back(rdata_o);
            if (done_o) begin got = 1; gerr = err_code_o; dcyc = c; end
            wdata_valid = 0;
            if (!got && !op && widx < len && $urandom_range(0, 3) != 0) begin
                wdata_valid = 1; wdata = wbytes[widx];
                if (wdata_ready_o) widx++;
            end
        end
        check("done_seen", got, 1'b1);
        check("err_code", gerr, exp_err);
        check("trace_len", trace.size(), exp_q.size());
        check("trace_data", trace_eq(), 1'b1);
        rd_ok = (got_rd.size() == exp_rd.size());
        foreach (got_rd[i]) if (rd_ok && got_rd[i] !== exp_rd[i]) rd_ok = 0;
        check("rd_count", got_rd.size(), exp_rd.size());
        check("rd_data", rd_ok, 1'b1);
        @(negedge clk);
        check("done_pulse", done_o, 1'b0);
        check("err_hold", err_code_o, exp_err);
        nak_at = -1; al_at = -1; hang_at = -1;
    endtask

    task automatic randomize_bytes();
        for (int i = 0; i < MAXB; i++) begin
            wbytes[i] = 8'($urandom); rbytes[i] = 8'($urandom);
        end
    endtask

    initial begin
        int c, dones;
        bit hit, prev;
        rst = 1; req_valid = 0; req_bus = 0; req_addr = 0; req_op = 0; req_len = 0;
        wdata_valid = 0; wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wdata_ready_o,
                                rdata_valid_o, rdata_o, done_o, err_code_o}, 0);
        rst = 0;
        wait_idle("init_done");
        check("init_count", trace.size(), 1);
        check("init_csr", trace[0], {2'd0, 8'hC0});

        for (int i = 0; i < 4; i++) wbytes[i] = 8'h10 + 8'(i);
        run_txn(4'd0, 7'h22, 1'b0, 4);
        for (int i = 0; i < 32; i++) rbytes[i] = 8'(100 + i);
        run_txn(4'd0, 7'h22, 1'b1, 32);

        run_txn(4'd2, 7'h10, 1'b0, 3);
        check("reject_latency", dcyc, 1);
        check("reject_no_wb", nacc - nacc_base, 0);
        run_txn(4'd1, 7'h10, 1'b1, MAXB + 1);
        check("reject_len_no_wb", nacc - nacc_base, 0);

        randomize_bytes();
        run_txn(4'd1, 7'($urandom), 1'b0, int'($urandom_range(1, 8)));
        nak_at = (mc_vld && mc_bus == 4'd1) ? 1 : 2;
        run_txn(4'd1, 7'($urandom), 1'b0, 5);
        randomize_bytes();
        nak_at = 1 + 1 + 2;
        run_txn(4'd1, 7'($urandom), 1'b1, 6);
        al_at = 0;
        run_txn(4'd1, 7'($urandom), 1'b1, 3);
        run_txn(4'd1, 7'($urandom), 1'b0, 2);
        hang_at = (mc_vld && mc_bus == 4'd0) ? 1 : 2;
        run_txn(4'd0, 7'($urandom), 1'b0, 2);
        run_txn(4'd0, 7'h33, 1'b1, 0);
        run_txn(4'd0, 7'h34, 1'b0, 0);
        for (int t = 0; t < 3; t++) begin
            randomize_bytes();
            run_txn(4'($urandom_range(0, 1)), 7'($urandom), 1'($urandom), int'($urandom_range(0, 10)));
        end

        // Reset in the middle of an access, then confirm re-initialisation.
        slow = 1;
        wait_idle("idle_before_rst");
        slv_rd.delete(); cmd_idx = 0; nacc_base = nacc;
        req_valid = 1; req_bus = 0; req_addr = 7'h11; req_op = 1; req_len = 2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        hit = 0; prev = stb_o; c = 0;
        while (!hit && c < 500) begin
            @(negedge clk); c++;
            if (stb_o && !prev && nacc - nacc_base >= 2) hit = 1;
            prev = stb_o;
        end
        check("rst_point_found", hit, 1'b1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_cyc_stb", {cyc_o, stb_o}, 2'b00);
        check("rst_mid_done", done_o, 1'b0);
        rst = 0; slow = 0; trace.delete(); mc_vld = 0;
        dones = 0; c = 0;
        @(negedge clk);
        while (!req_ready_o && c < 300) begin
            if (done_o) dones++;
            @(negedge clk); c++;
        end
        check("rst_no_done", dones, 0);
        check("rst_reinit_count", trace.size(), 1);
        check("rst_reinit_csr", trace[0], {2'd0, 8'hC0});
        randomize_bytes();
        run_txn(4'd0, 7'h22, 1'b0, 3);

        check("wb_protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
